// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types, baud divider and frame-length helpers
package uart_pkg;
  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  function automatic int calc_div(input longint clk_freq, input longint baud, input longint os);
    longint den;
    longint d;
    den = baud * os;
    d = (clk_freq + den / 2) / den;
    return (d < 1) ? 1 : int'(d);
  endfunction
  function automatic int frame_len(input int data_bits, input int parity_en, input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction
  localparam int FRAME_LEN_8N1 = frame_len(8, 0, 1);
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running one-cycle oversample tick every DIV clocks
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == LAST;
  always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised full-duplex UART with 16x-oversampled receiver and loopback
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] OS_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SB_LAST = 4'(STOP_BITS - 1);
  localparam logic ODD = PARITY_ODD != 0;
  logic tick;
  uart_tick_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk(clk), .rst_n(rst_n), .tick(tick)
  );
  tx_state_t tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic tx_par_q, tx_par_d, txd_q, txd_d, tx_end;
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_end = tick && tx_cnt_q == OS_LAST;
    if (tick && tx_state_q != TX_IDLE && tx_state_q != TX_WAIT) tx_cnt_d = tx_end ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: if (tx_valid) begin
        tx_state_d = TX_WAIT;
        tx_sh_d = tx_data;
        tx_par_d = ^tx_data ^ ODD;
      end
      TX_WAIT: if (tick) begin
        tx_state_d = TX_START;
        tx_cnt_d = '0;
      end
      TX_START: if (tx_end) begin
        tx_state_d = TX_DATA;
        tx_bit_d = '0;
      end
      TX_DATA: if (tx_end) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q == DB_LAST ? '0 : tx_bit_q + 1'b1;
        if (tx_bit_q == DB_LAST) tx_state_d = PARITY_EN != 0 ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (tx_end) tx_state_d = TX_STOP;
      TX_STOP: if (tx_end) begin
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == SB_LAST) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // txd is registered from the next state so the pin changes on the same edge as the FSM
    txd_d = tx_state_d == TX_START ? 1'b0 : tx_state_d == TX_DATA ? tx_sh_d[0] :
            tx_state_d == TX_PARITY ? tx_par_q : 1'b1;
  end
  assign tx_ready = tx_state_q == TX_IDLE;
  assign txd = txd_q;
  rx_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [2:0] sync_q, sync_d;
  logic lb_q, lb_d, rx_perr_q, rx_perr_d, rx_valid_q, rx_valid_d;
  logic rx_parity_err_q, rx_parity_err_d, rx_frame_err_q, rx_frame_err_d, rx_overrun_q, rx_overrun_d;
  logic rx_s, rx_samp, rx_done;
  assign rx_s = sync_q[1];
  always_comb begin
    lb_d = rx_state_q == RX_IDLE ? loopback : lb_q;
    sync_d = {sync_q[1:0], lb_q ? txd_q : rxd};
    rx_state_d = rx_state_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_perr_d = rx_perr_q;
    rx_data_d = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    rx_parity_err_d = rx_parity_err_q;
    rx_frame_err_d = rx_frame_err_q;
    rx_overrun_d = rx_overrun_q;
    rx_done = 1'b0;
    rx_samp = tick && rx_cnt_q == (rx_state_q == RX_START ? OS_MID : OS_LAST);
    if (tick && rx_state_q != RX_IDLE) rx_cnt_d = rx_samp ? '0 : rx_cnt_q + 1'b1;
    case (rx_state_q)
      // a falling edge needs a high history bit, so a held-low break line never re-arms
      RX_IDLE: if (sync_q[2] && !rx_s) begin
        rx_state_d = RX_START;
        rx_cnt_d = '0;
      end
      RX_START: if (rx_samp) begin
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        rx_bit_d = '0;
        rx_perr_d = 1'b0;
      end
      RX_DATA: if (rx_samp) begin
        rx_sh_d = {rx_s, rx_sh_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == DB_LAST) rx_state_d = PARITY_EN != 0 ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_samp) begin
        rx_perr_d = rx_s ^ (^rx_sh_q) ^ ODD;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_samp) begin
        rx_state_d = RX_IDLE;
        rx_done = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (rx_done && (!rx_valid_q || rx_ready)) begin
      rx_data_d = rx_sh_q;
      rx_parity_err_d = rx_perr_q;
      rx_frame_err_d = ~rx_s;
      rx_overrun_d = 1'b0;
      rx_valid_d = 1'b1;
    end else if (rx_done) rx_overrun_d = 1'b1;
  end
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_overrun = rx_overrun_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_par_q <= 1'b0;
      txd_q <= 1'b1;
      lb_q <= 1'b0;
      sync_q <= '1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_perr_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_par_q <= tx_par_d;
      txd_q <= txd_d;
      lb_q <= lb_d;
      sync_q <= sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_perr_q <= rx_perr_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_overrun_q <= rx_overrun_d;
    end
endmodule

// File: doc/uart_xcvr.md
Name: uart_xcvr

Overview:
- Parametrised full-duplex UART transceiver.
- Successor to the fixed 8N1 baud_gen/uart_tx/uart_rx trio: configurable data width, optional parity, 1 or 2 stop bits, 16x-oversampled receiver with mid-bit sampling, error flags, valid/ready handshakes, internal loopback mode.
- Sits between the system clock domain and the board txd/rxd pins.
- Instantiated by top-level wrappers and driven by CPU-side or test logic.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit period; even, at least 8.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY_EN, 0, 1 inserts and checks a parity bit.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- STOP_BITS, 1, transmitted stop bits; 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_BITS  payload to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter idle; accepts a byte this cycle.
- txd  out  1  serial output; idles high.
- rxd  in  1  serial input; asynchronous to clk.
- loopback  in  1  1 routes internal txd into the receiver in place of rxd.
- rx_data  out  DATA_BITS  received payload.
- rx_valid  out  1  rx_data and the flags are valid; held until accepted.
- rx_ready  in  1  consumer accepts rx_data.
- rx_parity_err  out  1  parity mismatch on the frame in rx_data.
- rx_frame_err  out  1  stop bit sampled low on the frame in rx_data.
- rx_overrun  out  1  at least one frame was dropped while rx_valid was high.

Behaviour:
- Reset (asynchronous, all outputs):
  - txd=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags=0.
  - Synchroniser flops=1; both FSMs return to IDLE; tick counter=0.
- Tick generator:
  - DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)), minimum 1.
  - tick is a one-cycle pulse every DIV clocks, free-running from reset.
  - One bit period = OVERSAMPLE ticks.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - tx_ready=1 only in IDLE.
  - A handshake (tx_valid & tx_ready) latches tx_data; tx_ready drops the next cycle.
  - START begins at the first tick after the handshake.
  - DATA shifts LSB first, DATA_BITS bits.
  - PARITY bit is XOR of the payload, inverted when PARITY_ODD=1.
  - STOP drives 1 for STOP_BITS bit periods; tx_ready returns high in the cycle after the last stop tick.
  - tx_data changes while busy are ignored.
- RX path:
  - Input mux selects rxd or internal txd per loopback, then a 2-flop synchroniser.
  - loopback is sampled only while the RX FSM is in IDLE.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a high-to-low on the synchronised input resets the sample counter and enters START.
  - START: samples at OVERSAMPLE/2 ticks. If high, treat as a false start and return to IDLE with no output.
  - DATA and PARITY: sample every OVERSAMPLE ticks after that, i.e. mid-bit.
  - STOP: samples one stop bit only, even when STOP_BITS=2. Returns to IDLE immediately after the stop sample, so back-to-back frames are tolerated.
- Frame completion, rx_valid=0 or (rx_valid & rx_ready) in the same cycle:
  - Load rx_data, rx_parity_err and rx_frame_err; rx_valid=1 the next cycle.
  - rx_overrun is set if a frame was dropped since the last accept, else cleared.
- Frame completion while rx_valid=1 and rx_ready=0:
  - The new frame is discarded; held data and flags are unchanged; rx_overrun set to 1.
- Handshake (rx_valid & rx_ready) with no frame completing: rx_valid=0 next cycle.
- Frame error:
  - Data is still delivered with rx_frame_err=1.
  - If the line is still low after STOP, IDLE waits for the line to go high before arming edge detection (break condition).
- Reset mid-frame: both FSMs abort; txd is forced high immediately (asynchronously); the partial frame is not delivered.

Decomposition:
- Shared package uart_pkg:
  - tx_state_t and rx_state_t enums.
  - calc_div function computing DIV.
  - Localparams for frame length (1 + DATA_BITS + PARITY_EN + STOP_BITS).
- Sub-module uart_tick_gen (parameters CLK_FREQ, BAUD, OVERSAMPLE; outputs tick).
- TX and RX FSMs stay in uart_xcvr.

Test Plan:
Common setup: CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16, so DIV=10 and one bit = 160 clk.
1. 8N1 loopback: tx 0xA5, rx_ready=1 -> txd bit pattern 0,1,0,1,0,0,1,0,1,1 at 160-clk spacing; rx_data=0xA5, no flags; tx_ready high 1600 clk after the handshake (±10).
2. PARITY_EN=1, PARITY_ODD=0, drive rxd with 0x07 and parity bit 0 -> rx_data=0x07, rx_parity_err=1; repeat with parity 1 -> rx_parity_err=0.
3. Drive rxd with stop bit 0 for 0x3C -> rx_data=0x3C, rx_frame_err=1; hold rxd low afterward -> no new rx_valid until rxd goes high, then a valid frame is received.
4. rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun=1; accept, then send 0x33 -> rx_data=0x33, rx_overrun=0.
5. 60-clk low glitch on rxd -> no rx_valid, RX FSM back in IDLE, next frame 0x5A received correctly.
6. Assert rst_n=0 during DATA of tx 0xFF -> txd=1 and tx_ready=1 immediately; after release, tx 0x81 transmits cleanly; DATA_BITS=7, STOP_BITS=2 build gives 0x81&0x7F=0x01 with two high stop periods.
